// File: rtl/pwm_ramp_ctrl_if.sv
// Peripheral register bus between the core and the PWM ramp controller.
// The master drives write strobe, address and write data, and the slave returns combinational read data.
interface pwm_ramp_ctrl_if #(
  parameter int CR_W = 16
) ();
  logic            we;
  logic [1:0]      addr;
  logic [CR_W-1:0] wdata;
  logic [CR_W-1:0] rdata;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: ramps the PWM compare value toward a programmed target,
// advancing one step per (div+1) PWM periods and only at period boundaries.
module pwm_ramp_ctrl #(
  parameter int CR_W  = 16,
  parameter int DIV_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pwm_ramp_ctrl_if.slave    bus,
  input  logic              i_period_end,
  output logic [CR_W-1:0]   o_cr,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t            state;
  logic [CR_W-1:0]   target;
  logic [CR_W-1:0]   step;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  divcnt;
  logic              enable;
  logic              dir;

  logic              tgt_wr;
  logic              step_wr;
  logic              div_wr;
  logic              ctrl_wr;
  logic [CR_W:0]     up_sum;
  logic [CR_W-1:0]   down_gap;
  logic [CR_W-1:0]   next_cr;

  assign tgt_wr  = bus.we && (bus.addr == 2'd0);
  assign step_wr = bus.we && (bus.addr == 2'd1);
  assign div_wr  = bus.we && (bus.addr == 2'd2);
  assign ctrl_wr = bus.we && (bus.addr == 2'd3);
  assign o_busy  = (state == RAMP);

  // Next compare value, clamped at the target so the ramp never wraps or underflows.
  always_comb begin
    up_sum   = {1'b0, o_cr} + {1'b0, step};
    down_gap = o_cr - target;
    next_cr  = target;
    if (step != '0) begin
      if (!dir) begin
        next_cr = (up_sum >= {1'b0, target}) ? target : up_sum[CR_W-1:0];
      end else begin
        next_cr = (down_gap <= step) ? target : (o_cr - step);
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0:    bus.rdata = target;
      2'd1:    bus.rdata = step;
      2'd2:    bus.rdata = {{(CR_W-DIV_W){1'b0}}, div};
      default: bus.rdata = {{(CR_W-3){1'b0}}, dir, o_busy, enable};
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      o_cr   <= '0;
      o_done <= 1'b0;
      target <= '0;
      step   <= {{(CR_W-1){1'b0}}, 1'b1};
      div    <= '0;
      divcnt <= '0;
      enable <= 1'b0;
      dir    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (step_wr) begin
        step <= bus.wdata;
      end
      if (div_wr) begin
        div <= bus.wdata[DIV_W-1:0];
      end
      // Disable overrides everything else happening in the same cycle.
      if (ctrl_wr && !bus.wdata[0]) begin
        enable <= 1'b0;
        o_cr   <= '0;
        state  <= IDLE;
      end else begin
        if (ctrl_wr) begin
          enable <= 1'b1;
        end
        if (tgt_wr) begin
          target <= bus.wdata;
          if (enable) begin
            if (bus.wdata == o_cr) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end else begin
              dir   <= (bus.wdata < o_cr);
              state <= RAMP;
              // A retarget keeps the running period count.
              if (state == IDLE) begin
                divcnt <= div;
              end
            end
          end
        end else if ((state == RAMP) && i_period_end) begin
          if (divcnt != '0) begin
            divcnt <= divcnt - 1'b1;
          end else begin
            divcnt <= div;
            o_cr   <= next_cr;
            if (next_cr == target) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: a per-cycle reference model compared on every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_pwm_ramp_ctrl;
  localparam int CR_W  = 16;
  localparam int DIV_W = 8;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b1;
  logic            i_period_end = 1'b0;
  logic [CR_W-1:0] o_cr;
  logic            o_busy;
  logic            o_done;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  pwm_ramp_ctrl_if #(.CR_W(CR_W)) bus ();

  pwm_ramp_ctrl #(.CR_W(CR_W), .DIV_W(DIV_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .bus          (bus.slave),
    .i_period_end (i_period_end),
    .o_cr         (o_cr),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state: a ramp takes mNeed period ends per step, mSeen counted so far.
  int mCr, mTarget, mStep, mDiv, mNeed, mSeen;
  bit mEn, mBusy, mDone, mDown;
  int nCr, nTarget, nStep, nDiv, nNeed, nSeen;
  bit nEn, nBusy, nDone, nDown, writeBlocksStep;

  function automatic int nextCompare(int cr, int tgt, int stp, bit down);
    if (stp == 0) return tgt;
    if (!down) return (cr + stp > tgt) ? tgt : cr + stp;
    return (cr - stp < tgt) ? tgt : cr - stp;
  endfunction

  function automatic int expectedRead(logic [1:0] a);
    case (a)
      2'd0:    return mTarget;
      2'd1:    return mStep;
      2'd2:    return mDiv;
      default: return mDown * 4 + mBusy * 2 + mEn;
    endcase
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mCr <= 0; mTarget <= 0; mStep <= 1; mDiv <= 0; mNeed <= 1; mSeen <= 0;
      mEn <= 0; mBusy <= 0; mDone <= 0; mDown <= 0;
    end else begin
      nCr = mCr; nTarget = mTarget; nStep = mStep; nDiv = mDiv; nNeed = mNeed; nSeen = mSeen;
      nEn = mEn; nBusy = mBusy; nDown = mDown; nDone = 0;
      writeBlocksStep = bus.we && (bus.addr == 2'd0 || bus.addr == 2'd3);
      if (mEn && mBusy && i_period_end && !writeBlocksStep) begin
        if (mSeen + 1 < mNeed) begin
          nSeen = mSeen + 1;
        end else begin
          nSeen = 0;
          nNeed = mDiv + 1;
          nCr = nextCompare(mCr, mTarget, mStep, mDown);
          if (nCr == mTarget) begin
            nBusy = 0;
            nDone = 1;
          end
        end
      end
      if (bus.we) begin
        case (bus.addr)
          2'd1: nStep = bus.wdata;
          2'd2: nDiv = bus.wdata[DIV_W-1:0];
          2'd3: begin
            nEn = bus.wdata[0];
            if (!nEn) begin
              nCr = 0;
              nBusy = 0;
            end
          end
          default: begin
            nTarget = bus.wdata;
            if (mEn) begin
              if (bus.wdata == mCr) begin
                nBusy = 0;
                nDone = 1;
              end else begin
                nDown = (bus.wdata < mCr);
                if (!mBusy) begin
                  nNeed = mDiv + 1;
                  nSeen = 0;
                end
                nBusy = 1;
              end
            end
          end
        endcase
      end
      mCr <= nCr; mTarget <= nTarget; mStep <= nStep; mDiv <= nDiv; mNeed <= nNeed; mSeen <= nSeen;
      mEn <= nEn; mBusy <= nBusy; mDone <= nDone; mDown <= nDown;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && checkEn) begin
      checkOutput("model_cr", o_cr, mCr);
      checkOutput("model_busy", o_busy, mBusy);
      checkOutput("model_done", o_done, mDone);
      checkOutput("model_rdata", bus.rdata, expectedRead(bus.addr));
    end
  end

  task automatic applyStimulus(input bit we, input logic [1:0] addr, input logic [CR_W-1:0] wdata,
                               input bit pe);
    bus.we = we;
    bus.addr = addr;
    bus.wdata = wdata;
    i_period_end = pe;
    @(posedge i_clk);
    #2;
    bus.we = 1'b0;
    i_period_end = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [CR_W-1:0] data);
    applyStimulus(1'b1, addr, data, 1'b0);
  endtask

  task automatic pulse();
    applyStimulus(1'b0, 2'd3, '0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd3, '0, 1'b0);
  endtask

  int upSeq[4] = '{30, 60, 90, 100};
  int downSeq[9] = '{100, 100, 60, 60, 60, 20, 20, 20, 10};

  initial begin
    bus.we = 1'b0;
    bus.addr = 2'd1;
    bus.wdata = '0;
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    checkOutput("reset_cr", o_cr, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_done", o_done, 0);
    checkOutput("reset_step", bus.rdata, 1);
    i_rst_n = 1'b1;
    checkEn = 1'b1;

    // Ramp up in steps of 30 to 100
    writeReg(2'd3, 16'd1);
    writeReg(2'd1, 16'd30);
    writeReg(2'd2, 16'd0);
    writeReg(2'd0, 16'd100);
    checkOutput("up_start_busy", o_busy, 1);
    checkOutput("up_start_cr", o_cr, 0);
    for (int i = 0; i < 4; i++) begin
      pulse();
      checkOutput("up_cr", o_cr, upSeq[i]);
      checkOutput("up_done", o_done, (i == 3) ? 1 : 0);
      idle(1);
    end
    checkOutput("up_busy_end", o_busy, 0);
    checkOutput("up_done_cleared", o_done, 0);

    // Ramp down with divider 2
    writeReg(2'd1, 16'd40);
    writeReg(2'd2, 16'd2);
    writeReg(2'd0, 16'd10);
    for (int i = 0; i < 9; i++) begin
      pulse();
      checkOutput("down_cr", o_cr, downSeq[i]);
    end
    checkOutput("down_done", o_done, 1);

    // Saturation at the top and bottom of the range
    writeReg(2'd2, 16'd0);
    writeReg(2'd1, 16'd0);
    writeReg(2'd0, 16'hFFF0);
    pulse();
    checkOutput("jump_cr", o_cr, 16'hFFF0);
    writeReg(2'd1, 16'h20);
    writeReg(2'd0, 16'hFFFF);
    pulse();
    checkOutput("sat_top_cr", o_cr, 16'hFFFF);
    checkOutput("sat_top_done", o_done, 1);
    writeReg(2'd1, 16'd0);
    writeReg(2'd0, 16'h10);
    pulse();
    checkOutput("jump_low_cr", o_cr, 16'h10);
    writeReg(2'd1, 16'h20);
    writeReg(2'd0, 16'h0);
    pulse();
    checkOutput("sat_bottom_cr", o_cr, 0);
    writeReg(2'd0, 16'h0);
    checkOutput("equal_target_done", o_done, 1);
    checkOutput("equal_target_busy", o_busy, 0);

    // Retarget colliding with a period end
    writeReg(2'd1, 16'd30);
    writeReg(2'd0, 16'd100);
    pulse();
    pulse();
    checkOutput("retgt_pre_cr", o_cr, 60);
    applyStimulus(1'b1, 2'd0, 16'd20, 1'b1);
    checkOutput("retgt_hold_cr", o_cr, 60);
    checkOutput("retgt_busy", o_busy, 1);
    bus.addr = 2'd3;
    #1;
    checkOutput("retgt_status", bus.rdata, 7);
    writeReg(2'd1, 16'd50);
    pulse();
    checkOutput("retgt_clamp_cr", o_cr, 20);
    checkOutput("retgt_done", o_done, 1);

    // Step write alongside an update, then disable mid-ramp
    writeReg(2'd3, 16'd0);
    writeReg(2'd3, 16'd1);
    writeReg(2'd1, 16'd30);
    writeReg(2'd0, 16'd100);
    pulse();
    applyStimulus(1'b1, 2'd1, 16'd5, 1'b1);
    checkOutput("old_step_cr", o_cr, 60);
    writeReg(2'd3, 16'hFFFE);
    checkOutput("disable_cr", o_cr, 0);
    checkOutput("disable_busy", o_busy, 0);
    checkOutput("disable_done", o_done, 0);
    pulse();
    pulse();
    checkOutput("disabled_hold_cr", o_cr, 0);
    bus.addr = 2'd0;
    #1;
    checkOutput("retained_target", bus.rdata, 100);

    // Asynchronous reset mid-ramp
    writeReg(2'd3, 16'd1);
    writeReg(2'd0, 16'd200);
    pulse();
    checkOutput("pre_reset_cr", o_cr, 5);
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("areset_cr", o_cr, 0);
    checkOutput("areset_busy", o_busy, 0);
    checkOutput("areset_done", o_done, 0);
    bus.addr = 2'd1;
    #1 checkOutput("areset_step", bus.rdata, 1);
    bus.addr = 2'd2;
    #1 checkOutput("areset_div", bus.rdata, 0);
    bus.addr = 2'd0;
    #1 checkOutput("areset_target", bus.rdata, 0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Bus-programmable duty-cycle sequencer that drives the 16-bit compare value of a PWM generator. Software writes a target duty, a step size and a step divider. The block ramps the compare value toward the target by one step per N PWM periods. It updates only at PWM period boundaries, so the PWM output never sees a mid-period compare change. It sits between the core's peripheral register bus and the PWM generator's compare input.

## Interface
- CR_W, 16, width of compare/target/step values
- DIV_W, 8, width of step-divider register
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_we  in  1  register write strobe, one cycle per write
- i_addr  in  2  register select: 0 TARGET, 1 STEP, 2 DIV, 3 CTRL/STATUS
- i_wdata  in  CR_W  write data
- i_period_end  in  1  one-cycle pulse from PWM generator when its counter wraps
- o_rdata  out  CR_W  combinational read of register at i_addr
- o_cr  out  CR_W  compare value to PWM generator
- o_busy  out  1  high while a ramp is in progress
- o_done  out  1  one-cycle pulse when o_cr reaches target

## Operation
- Registers:
  - TARGET: write also starts or retargets a ramp.
  - STEP: 0 means jump straight to target.
  - DIV: periods per step minus 1.
  - CTRL: bit0 = enable. Writes to bits other than bit0 are ignored.
- Reads:
  - addr 0 = target
  - addr 1 = step
  - addr 2 = zero-extended div
  - addr 3 = {zeros, dir, busy, enable}, where dir = 1 for down.
- Reset values: o_cr=0, target=0, step=1, div=0, enable=0, state IDLE, o_busy=0, o_done=0, divcnt=0.
- States: IDLE, RAMP. o_busy = (state==RAMP).
- TARGET write with enable=1:
  - Latch target.
  - If target==o_cr: stay or go IDLE and pulse o_done next cycle.
  - Otherwise: go RAMP, set dir = (target<o_cr), load divcnt=div.
- TARGET write while enable=0: latch target only, stay IDLE.
- RAMP, on i_period_end:
  - If divcnt!=0: decrement divcnt.
  - Otherwise: reload divcnt=div and update o_cr.
- o_cr update:
  - Up: sum = o_cr+step, computed at CR_W+1 bits. o_cr = (sum >= target) ? target : sum. No wrap past 0xFFFF.
  - Down: o_cr = (o_cr-target <= step) ? target : o_cr-step. Never underflows.
  - step==0: o_cr = target.
- When the updated o_cr equals target: go IDLE, pulse o_done for one cycle, coincident with the new o_cr.
- STEP/DIV writes during RAMP: new step is used at the next update; new div is used at the next divcnt reload. The current divcnt is not disturbed.
- Retarget (TARGET write in RAMP): recompute dir, divcnt unchanged. If new target == o_cr: go IDLE and pulse o_done.
- CTRL write enable=0: next cycle o_cr=0, state IDLE, o_busy=0, no o_done. target/step/div are retained.
- CTRL write enable=1 from disabled: o_cr stays 0. A ramp needs a TARGET write.
- Enable bit (CTRL bit0) clear: o_cr held at 0 regardless of i_period_end.

## Timing
- o_cr changes only in the cycle after a cycle with i_period_end=1. The only exceptions are disable and reset.
- First step after a TARGET write happens at the (div+1)-th i_period_end strictly after the write cycle.
- o_done, o_busy and o_cr are registered outputs. o_busy falls in the same cycle o_done rises.
- Simultaneous events in one cycle:
  - TARGET write + i_period_end: write wins, the period_end is ignored for stepping and divcnt.
  - CTRL disable + any other event: disable wins.
  - STEP write + step update: the update uses the old step.
- Asynchronous reset mid-ramp: all outputs return to reset values immediately. No o_done pulse.
- o_rdata is combinational from i_addr and current registers, zero-cycle latency. A write is visible on read the next cycle.

## Test plan
- Ramp up: enable, step=30, div=0, TARGET=100, then 4 period_end pulses -> o_cr 30, 60, 90, 100; o_done pulses once with the 100; o_busy 1→0.
- Ramp down with divider: from o_cr=100, step=40, div=2, TARGET=10 -> o_cr 60 after 3rd period_end, 20 after 6th, 10 after 9th, unchanged between.
- Saturation: o_cr=0xFFF0, TARGET=0xFFFF, step=0x20 -> o_cr=0xFFFF in one step, no wrap; down from 0x0010 to 0, step 0x20 -> 0.
- Retarget and collision: during an up-ramp at o_cr=60, write TARGET=20 in the same cycle as i_period_end -> no step that cycle, dir=down, next update gives 60-step clamped at 20.
- Disable mid-ramp: CTRL=0 at o_cr=60 -> o_cr=0 and o_busy=0 next cycle, no o_done, later period_end pulses leave o_cr=0.
- Reset mid-ramp: assert i_rst_n=0 asynchronously between clocks -> o_cr=0, o_busy=0, o_done=0 immediately; reads return step=1, div=0, target=0.
